riscv_aes_ld: RTL and testbench
===============================

// Module: riscv_aes_ld
// PURPOSE
//  Operand-load stage upstream of the AES core and its write-back unit. On start_aes_ld it halts
//  the core pipeline, reads NUM_WORDS consecutive 32-bit words from data memory via a req/gnt/rvalid
//  port, and assembles them into one block. It then pulses data_valid_out so the AES core can consume data_out.
// PARAMETERS
//  NUM_WORDS    4    words per block; data_out width = NUM_WORDS*32
//  ADDR_STRIDE  4    byte increment between word addresses
//  TIMEOUT_CYC  255  max wait cycles for gnt or rvalid (used only with AES_LD_TIMEOUT_EN)
// PORTS
//  clk             in   1             clock, all logic on posedge
//  rst             in   1             synchronous reset, active-high
//  start_aes_ld    in   1             start request, sampled only in IDLE
//  address_in      in   32            block base byte address, latched on accepted start
//  rd_req_out      out  1             memory read request
//  rd_addr_out     out  32            memory read address
//  rd_gnt_in       in   1             memory accepted request this cycle
//  rd_rvalid_in    in   1             rd_rdata_in valid this cycle
//  rd_rdata_in     in   32            read data
//  halt_en_out     out  1             stall core while loading
//  data_out        out  NUM_WORDS*32  assembled block; word i at [i*32+:32]
//  data_valid_out  out  1             one-cycle pulse: data_out complete
//  err_out         out  1             one-cycle pulse: load aborted (timeout)
// BEHAVIOUR
//  - Reset: all outputs 0, data_out 0, FSM IDLE, word counter 0, base address 0.
//  - Reset mid-load: next cycle FSM in IDLE, req/halt dropped, partial data_out cleared; no pulse.
//  - States: IDLE, REQ, WAIT_R, DONE.
//  - IDLE: start_aes_ld=1 -> latch base=address_in, cnt=0, halt_en_out=1, go REQ.
//  - REQ: rd_req_out=1, rd_addr_out=base+cnt*ADDR_STRIDE (32-bit wrap, no carry-out).
//    req/addr held stable until rd_gnt_in=1; on gnt -> WAIT_R, req drops next cycle.
//  - WAIT_R: rd_req_out=0. On rd_rvalid_in=1 capture rd_rdata_in into data_out[cnt*32+:32];
//    cnt==NUM_WORDS-1 -> DONE, else cnt+1 -> REQ.
//  - rvalid arrives at earliest the cycle after gnt; rvalid in IDLE/REQ/DONE ignored.
//  - DONE: data_valid_out=1 for exactly this cycle, halt_en_out=0 from next cycle, go IDLE.
//  - halt_en_out=1 from the cycle after accepted start through DONE inclusive.
//  - data_out holds last completed block until next start's first capture; words of a new block
//    overwrite in order, untouched words keep old values until written.
//  - start_aes_ld outside IDLE ignored (no queueing); start in DONE cycle ignored.
//  - Min latency (gnt same cycle as req, rvalid next): start -> data_valid = 2*NUM_WORDS+2 cycles.
//  - No outstanding-request overlap: one transaction in flight at a time.
// CONFIGURATION
//  AES_LD_TIMEOUT_EN defined: wait counter cleared on entering REQ/WAIT_R, increments each
//    cycle waiting; reaching TIMEOUT_CYC without gnt (REQ) or rvalid (WAIT_R) -> err_out=1 for
//    one cycle, req/halt drop, FSM IDLE, no data_valid_out, data_out keeps captured words.
//  Not defined: waits indefinitely; err_out tied 0; no wait counter logic.
// TESTING
//  1 base=0x1000, gnt with req, rvalid +1 cyc, data 0x11111111..0x44444444 -> addrs 0x1000/04/08/0C,
//    data_out=0x44444444_33333333_22222222_11111111, data_valid 10 cyc after start, one pulse.
//  2 gnt delayed 3 cyc on word 1 -> rd_req_out/rd_addr_out=0x1004 stable all 4 cycles, result same.
//  3 base=0xFFFFFFF8 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004 (wrap).
//  4 start pulsed while busy and in DONE -> ignored; only one block loaded, one data_valid pulse.
//  5 rst=1 during WAIT_R of word 2 -> next cycle req=0, halt=0, data_out=0, no data_valid.
//  6 AES_LD_TIMEOUT_EN, TIMEOUT_CYC=8, no rvalid -> err_out pulse, halt drops, no data_valid.

Source files
------------

// File: rtl/riscv_aes_ld.sv
// Purpose : operand-load stage for the AES core. On start it stalls the core, fetches NUM_WORDS
//           consecutive 32-bit words over a req/gnt/rvalid port and presents them as one block.
// Latency : 2*NUM_WORDS+2 cycles from the start cycle to the data_valid_out cycle, both counted,
//           when gnt arrives with req and rvalid follows one cycle later.
// Backpr. : rd_req_out/rd_addr_out are held until rd_gnt_in. Only one read is in flight at a time.
//           start_aes_ld is ignored unless the FSM is idle.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   start_aes_ld, address_in      load request; block base byte address, latched on accept
//   rd_req_out, rd_addr_out       memory read request and byte address
//   rd_gnt_in                     memory accepted the request this cycle
//   rd_rvalid_in, rd_rdata_in     read data return
//   halt_en_out                   core stall, high from the cycle after start through DONE
//   data_out                      assembled block, word i at [i*32+:32]
//   data_valid_out                one-cycle pulse: data_out holds a complete block
//   err_out                       one-cycle pulse: load aborted on timeout
//
// Optional feature: define AES_LD_TIMEOUT_EN to abort a load after TIMEOUT_CYC cycles spent
// waiting for gnt or rvalid. Without it the FSM waits indefinitely and err_out is constant 0.
module riscv_aes_ld #(
    parameter int NUM_WORDS   = 4,
    parameter int ADDR_STRIDE = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_aes_ld,
    input  logic [31:0]            address_in,
    output logic                   rd_req_out,
    output logic [31:0]            rd_addr_out,
    input  logic                   rd_gnt_in,
    input  logic                   rd_rvalid_in,
    input  logic [31:0]            rd_rdata_in,
    output logic                   halt_en_out,
    output logic [NUM_WORDS*32-1:0] data_out,
    output logic                   data_valid_out,
    output logic                   err_out
);

    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [CW-1:0]           cnt;
    logic [31:0]             base;
    logic [NUM_WORDS*32-1:0] data_q;
    logic [31:0]             word_addr;
    logic                    start_acc;
    logic                    capture;
    logic                    last_word;
    logic                    timeout;

    assign last_word = (cnt == CW'(NUM_WORDS - 1));
    // Plain 32-bit add: addresses past 0xFFFFFFFF wrap to low memory.
    assign word_addr = base + ({{(32 - CW){1'b0}}, cnt} * 32'(ADDR_STRIDE));
    assign data_out  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d        = state;
        start_acc      = 1'b0;
        capture        = 1'b0;
        rd_req_out     = 1'b0;
        rd_addr_out    = '0;
        halt_en_out    = 1'b1;
        data_valid_out = 1'b0;
        case (state)
            IDLE: begin
                halt_en_out = 1'b0;
                if (start_aes_ld) begin
                    start_acc = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                rd_req_out  = 1'b1;
                rd_addr_out = word_addr;
                if (rd_gnt_in) begin
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                if (rd_rvalid_in) begin
                    capture = 1'b1;
                    state_d = last_word ? DONE : REQ;
                end
            end
            DONE: begin
                data_valid_out = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // timeout only fires while waiting with no response, so it never races a capture
        if (timeout) begin
            state_d = IDLE;
        end
    end

    // Block assembly. Earlier block contents stay visible until each word is overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            base   <= '0;
            data_q <= '0;
        end else if (start_acc) begin
            base <= address_in;
            cnt  <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (cnt == CW'(i)) begin
                    data_q[i*32 +: 32] <= rd_rdata_in;
                end
            end
            if (!last_word) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef AES_LD_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [WW-1:0] wait_cnt;
    logic          waiting;
    logic          err_q;

    assign waiting = ((state == REQ) && !rd_gnt_in) || ((state == WAIT_R) && !rd_rvalid_in);
    // wait_cnt holds the number of earlier idle cycles in this state, so the abort lands
    // on the TIMEOUT_CYC-th unanswered cycle.
    assign timeout = waiting && (wait_cnt == WW'(TIMEOUT_CYC - 1));
    assign err_out = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout;
            if ((state_d != state) || !waiting) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end
`else
    // No abort path: the load waits as long as memory takes.
    assign timeout = 1'b0;
    assign err_out = (TIMEOUT_CYC == 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_riscv_aes_ld.sv
`timescale 1ns/1ps
module tb_riscv_aes_ld;

    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_aes_ld;
    logic [31:0]   address_in;
    logic          rd_req_out;
    logic [31:0]   rd_addr_out;
    logic          rd_gnt_in;
    logic          rd_rvalid_in;
    logic [31:0]   rd_rdata_in;
    logic          halt_en_out;
    logic [127:0]  data_out;
    logic          data_valid_out;
    logic          err_out;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;

    logic [31:0]   addr_q[$];
    logic [127:0]  blk_q[$];
    logic [127:0]  shadow;   // what data_out is expected to hold right now

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_aes_ld #(
        .NUM_WORDS  (NW),
        .ADDR_STRIDE(4),
        .TIMEOUT_CYC(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_aes_ld  (start_aes_ld),
        .address_in    (address_in),
        .rd_req_out    (rd_req_out),
        .rd_addr_out   (rd_addr_out),
        .rd_gnt_in     (rd_gnt_in),
        .rd_rvalid_in  (rd_rvalid_in),
        .rd_rdata_in   (rd_rdata_in),
        .halt_en_out   (halt_en_out),
        .data_out      (data_out),
        .data_valid_out(data_valid_out),
        .err_out       (err_out)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One block load with a bench-side memory responder. Inputs change on negedges,
    // outputs are checked on negedges.
    //   dly_word/dly : hold off gnt for dly cycles on word dly_word (-1 = never)
    //   spam         : keep start high (with a bogus address) for the whole load incl. DONE
    //   min_lat      : check the start-to-valid latency
    //   abort_word   : assert rst in the WAIT_R cycle of that word (-1 = never)
    task automatic run_load(input logic [31:0] base, input logic [127:0] blk,
                            input int dly_word, input int dly, input bit spam,
                            input bit min_lat, input int abort_word);
        int w = 0;
        int left;
        int t0;
        int guard = 0;
        bit rv_pending = 1'b0;
        bit done = 1'b0;
        bit aborted = 1'b0;
        for (int i = 0; i < NW; i++) addr_q.push_back(base + 32'(4 * i));
        blk_q.push_back(blk);
        @(negedge clk);
        start_aes_ld = 1'b1;
        address_in   = base;
        t0           = cyc;
        left         = (dly_word == 0) ? dly : 0;
        while (!done && guard < 100) begin
            @(negedge clk);
            guard++;
            start_aes_ld = spam;
            if (spam) address_in = 32'hDEAD0000;
            rd_gnt_in    = 1'b0;
            rd_rvalid_in = 1'b0;
            rd_rdata_in  = '0;
            check("data_hold", data_out, shadow);
            check("halt_busy", halt_en_out, 1'b1);
            check("no_err", err_out, 1'b0);
            if (data_valid_out) begin
                done = 1'b1;
                check("done_req", rd_req_out, 1'b0);
                // start cycle and valid cycle both counted: 2*NW+2 cycles = 2*NW+1 edges apart
                if (min_lat) check("latency", 128'(cyc - t0), 128'(2 * NW + 1));
                check("block", data_out, blk_q.pop_front());
            end else if (rv_pending) begin
                check("wait_req", rd_req_out, 1'b0);
                if (w == abort_word) begin
                    rst     = 1'b1;
                    done    = 1'b1;
                    aborted = 1'b1;
                end else begin
                    rd_rvalid_in        = 1'b1;
                    rd_rdata_in         = blk[w*32 +: 32];
                    shadow[w*32 +: 32]  = blk[w*32 +: 32];
                    rv_pending          = 1'b0;
                    w++;
                    left = (w == dly_word) ? dly : 0;
                end
            end else begin
                check("req", rd_req_out, 1'b1);
                check("addr", rd_addr_out, addr_q[0]);
                if (left == 0) begin
                    rd_gnt_in = 1'b1;
                    void'(addr_q.pop_front());
                    rv_pending = 1'b1;
                end else begin
                    left--;
                end
            end
        end
        check("load_finished", done, 1'b1);
        @(negedge clk);
        start_aes_ld = 1'b0;
        rd_gnt_in    = 1'b0;
        rd_rvalid_in = 1'b0;
        if (aborted) begin
            rst = 1'b0;
            shadow = '0;
            addr_q.delete();
            blk_q.delete();
            check("rst_req", rd_req_out, 1'b0);
            check("rst_halt", halt_en_out, 1'b0);
            check("rst_data", data_out, 128'h0);
            check("rst_valid", data_valid_out, 1'b0);
        end else begin
            check("valid_pulse", data_valid_out, 1'b0);
            check("halt_drop", halt_en_out, 1'b0);
            check("idle_req", rd_req_out, 1'b0);
        end
        // nothing should start on its own afterwards
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_quiet_req", rd_req_out, 1'b0);
            check("idle_quiet_valid", data_valid_out, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int  n_wait;
        bit  got_err;
        bit  saw_valid;
        rst          = 1'b1;
        start_aes_ld = 1'b0;
        address_in   = '0;
        rd_gnt_in    = 1'b0;
        rd_rvalid_in = 1'b0;
        rd_rdata_in  = '0;
        shadow       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_req", rd_req_out, 1'b0);
        check("reset_addr", rd_addr_out, 32'h0);
        check("reset_halt", halt_en_out, 1'b0);
        check("reset_data", data_out, 128'h0);
        check("reset_valid", data_valid_out, 1'b0);
        check("reset_err", err_out, 1'b0);
        rst = 1'b0;

        // 1: minimum latency load
        run_load(32'h0000_1000, 128'h44444444_33333333_22222222_11111111, -1, 0, 1'b0, 1'b1, -1);
        check("blk1_const", data_out, 128'h44444444_33333333_22222222_11111111);

        // 2: gnt held off 3 cycles on word 1, request must stay put
        run_load(32'h0000_1000, 128'h44444444_33333333_22222222_11111111, 1, 3, 1'b0, 1'b0, -1);

        // 3: address wrap past 0xFFFFFFFF, new data so partial overwrite is visible
        run_load(32'hFFFF_FFF8, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0, -1, 0, 1'b0, 1'b1, -1);

        // 4: start held high while busy and during DONE
        run_load(32'h0000_2000, 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000, -1, 0, 1'b1, 1'b1, -1);

        // 5: reset during WAIT_R of word 2
        run_load(32'h0000_3000, 128'h5555_0003_5555_0002_5555_0001_5555_0000, -1, 0, 1'b0, 1'b0, 2);

        // 6: memory grants word 0 but never returns data
        @(negedge clk);
        start_aes_ld = 1'b1;
        address_in   = 32'h0000_4000;
        @(negedge clk);
        start_aes_ld = 1'b0;
        check("to_req", rd_req_out, 1'b1);
        check("to_addr", rd_addr_out, 32'h0000_4000);
        rd_gnt_in = 1'b1;
        @(negedge clk);
        rd_gnt_in = 1'b0;
        n_wait    = 0;
        got_err   = 1'b0;
        saw_valid = 1'b0;
`ifdef AES_LD_TIMEOUT_EN
        n_wait = 1;   // this WAIT_R cycle is the first unanswered one
        for (int k = 0; k < 40 && !got_err; k++) begin
            @(negedge clk);
            if (data_valid_out) saw_valid = 1'b1;
            if (err_out) got_err = 1'b1;
            else if (halt_en_out && !rd_req_out) n_wait++;
        end
        check("to_err_seen", got_err, 1'b1);
        check("to_wait_cycles", 128'(n_wait), 128'(8));
        check("to_halt", halt_en_out, 1'b0);
        check("to_req_drop", rd_req_out, 1'b0);
        check("to_no_valid", saw_valid, 1'b0);
        check("to_data_kept", data_out, shadow);
        @(negedge clk);
        check("to_err_pulse", err_out, 1'b0);
`else
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (err_out) got_err = 1'b1;
            if (data_valid_out) saw_valid = 1'b1;
        end
        check("nto_err_tied", got_err, 1'b0);
        check("nto_no_valid", saw_valid, 1'b0);
        check("nto_still_halt", halt_en_out, 1'b1);
        check("nto_data_kept", data_out, shadow);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("nto_recover_halt", halt_en_out, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
